// File: rtl/decode_pkg.sv
// Shared types, opcode constants and pure decode helpers for the decode stage.
package decode_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned IMM_W   = 8;

    // ALU operation selects carried in ctrl_t.s_alu
    localparam logic [ALU_W-1:0] IADD = 4'd0;
    localparam logic [ALU_W-1:0] ISUB = 4'd1;
    localparam logic [ALU_W-1:0] IAND = 4'd2;
    localparam logic [ALU_W-1:0] IOR  = 4'd3;
    localparam logic [ALU_W-1:0] IXOR = 4'd4;
    localparam logic [ALU_W-1:0] ISLL = 4'd5;
    localparam logic [ALU_W-1:0] ISLR = 4'd6;
    localparam logic [ALU_W-1:0] ISRL = 4'd7;
    localparam logic [ALU_W-1:0] ISRA = 4'd8;
    localparam logic [ALU_W-1:0] IIDT = 4'd9;
    localparam logic [ALU_W-1:0] INON = 4'd10;

    // Instruction classes, instr[15:14]
    localparam logic [1:0] CLS_LOAD  = 2'b00;
    localparam logic [1:0] CLS_STORE = 2'b01;
    localparam logic [1:0] CLS_IMM   = 2'b10;
    localparam logic [1:0] CLS_ALU   = 2'b11;

    // ALU-class sub-ops, instr[7:4]; everything up to OP_IN writes Rd except CMP
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SLR = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_ADC = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;

    // Immediate-class sub-groups, instr[13:11]; all others are branches
    localparam logic [2:0] SUB_LI   = 3'b000;
    localparam logic [2:0] SUB_ADDI = 3'b001;

    typedef struct packed {
        logic [ALU_W-1:0]   s_alu;
        logic               wr;
        logic [FIELD_W-1:0] wr_addr;
        logic               flag_write;
        logic               pc_load;
        logic               mem_we;
        logic               in_mux;
        logic               out_en;
        logic               sign_ex;
        logic [2:0]         cond;
        logic [IMM_W-1:0]   imm;
    } ctrl_t;

    typedef struct packed {
        logic               a_en;
        logic [FIELD_W-1:0] a;
        logic               b_en;
        logic [FIELD_W-1:0] b;
    } src_t;

    typedef struct packed {
        logic               en;
        logic [FIELD_W-1:0] addr;
    } dst_t;

    // Destination register of an instruction, if any
    function automatic dst_t dst_reg(input logic [INSTR_W-1:0] instr);
        dst_t d;
        d = '0;
        case (instr[15:14])
            CLS_ALU: begin
                d.en   = (instr[7:4] <= OP_IN) && (instr[7:4] != OP_CMP);
                d.addr = instr[10:8];
            end
            CLS_LOAD: begin
                d.en   = 1'b1;
                d.addr = instr[13:11];
            end
            CLS_STORE: d = '0;
            default: begin
                d.en   = (instr[13:11] == SUB_LI) || (instr[13:11] == SUB_ADDI);
                d.addr = instr[10:8];
            end
        endcase
        return d;
    endfunction

    // Source registers read by an instruction
    function automatic src_t src_regs(input logic [INSTR_W-1:0] instr);
        src_t s;
        s = '0;
        s.a = instr[13:11];
        s.b = instr[10:8];
        case (instr[15:14])
            CLS_ALU: begin
                s.a_en = 1'b1;
                s.b_en = 1'b1;
            end
            CLS_LOAD:  s.b_en = 1'b1;
            CLS_STORE: begin
                s.a_en = 1'b1;
                s.b_en = 1'b1;
            end
            default:   s.b_en = (instr[13:11] == SUB_ADDI);
        endcase
        return s;
    endfunction

    // Full control bundle; wr/wr_addr follow dst_reg()
    function automatic ctrl_t decode(input logic [INSTR_W-1:0] instr);
        ctrl_t c;
        dst_t  d;
        c         = '0;
        d         = dst_reg(instr);
        c.wr      = d.en;
        c.wr_addr = d.addr;
        case (instr[15:14])
            CLS_ALU: begin
                c.imm = {4'h0, instr[3:0]};
                case (instr[7:4])
                    OP_ADD: begin c.s_alu = IADD; c.flag_write = 1'b1; end
                    OP_SUB: begin c.s_alu = ISUB; c.flag_write = 1'b1; end
                    OP_AND: begin c.s_alu = IAND; c.flag_write = 1'b1; end
                    OP_OR:  begin c.s_alu = IOR;  c.flag_write = 1'b1; end
                    OP_XOR: begin c.s_alu = IXOR; c.flag_write = 1'b1; end
                    OP_CMP: begin c.s_alu = ISUB; c.flag_write = 1'b1; end
                    OP_MOV: c.s_alu = IIDT;
                    OP_SLL: begin c.s_alu = ISLL; c.flag_write = 1'b1; end
                    OP_SLR: begin c.s_alu = ISLR; c.flag_write = 1'b1; end
                    OP_SRL: begin c.s_alu = ISRL; c.flag_write = 1'b1; end
                    OP_SRA: begin c.s_alu = ISRA; c.flag_write = 1'b1; end
                    OP_ADC: begin c.s_alu = IADD; c.flag_write = 1'b1; end
                    OP_IN:  begin c.s_alu = IIDT; c.in_mux = 1'b1; end
                    OP_OUT: begin c.s_alu = IIDT; c.out_en = 1'b1; end
                    default: c.s_alu = INON;
                endcase
            end
            CLS_LOAD: begin
                c.s_alu   = IADD;
                c.in_mux  = 1'b1;
                c.sign_ex = 1'b1;
                c.imm     = instr[7:0];
            end
            CLS_STORE: begin
                c.s_alu   = IADD;
                c.mem_we  = 1'b1;
                c.sign_ex = 1'b1;
                c.imm     = instr[7:0];
            end
            default: begin
                c.sign_ex = 1'b1;
                c.imm     = instr[7:0];
                case (instr[13:11])
                    SUB_LI:   c.s_alu = IIDT;
                    SUB_ADDI: begin c.s_alu = IADD; c.flag_write = 1'b1; end
                    default: begin
                        c.s_alu   = INON;
                        c.pc_load = 1'b1;
                        c.cond    = instr[10:8];
                    end
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register outstanding-write counters with RAW/saturation hazard query.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned NREG     = 8,
    parameter int unsigned SB_CNT_W = 2,
    localparam int unsigned REG_AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    input  logic [REG_AW-1:0] inc_addr,
    input  logic              dec_en,
    input  logic [REG_AW-1:0] dec_addr,
    input  logic              undo_en,
    input  logic [REG_AW-1:0] undo_addr,
    input  logic              rd_a_en,
    input  logic [REG_AW-1:0] rd_a,
    input  logic              rd_b_en,
    input  logic [REG_AW-1:0] rd_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    output logic              hazard_c,
    output logic              sb_err
);

    // Two extra bits so +1 and -2 never wrap before the floor check
    localparam int unsigned SW = SB_CNT_W + 2;

    logic [SB_CNT_W-1:0] cnt_q [NREG];
    logic [SB_CNT_W-1:0] cnt_d [NREG];
    logic [SW-1:0]       sum_c [NREG];
    logic [SW-1:0]       sub_c [NREG];
    logic                err_c;
    logic                sb_err_q;
    logic                sb_err_d;

    // Counter next-state: issue increments, retire and flush-undo decrement, floor at zero
    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            sum_c[i] = SW'(cnt_q[i]) + SW'(inc_en && (inc_addr == REG_AW'(i)));
            sub_c[i] = SW'(dec_en && (dec_addr == REG_AW'(i)))
                     + SW'(undo_en && (undo_addr == REG_AW'(i)));
            if (sum_c[i] >= sub_c[i]) begin
                cnt_d[i] = SB_CNT_W'(sum_c[i] - sub_c[i]);
            end else begin
                cnt_d[i] = '0;
                err_c    = 1'b1;
            end
        end
        sb_err_d = sb_err_q | err_c;
    end

    // Hazard: a source still has a pending writer, or the destination counter is full
    always_comb begin
        hazard_c = 1'b0;
        if (rd_a_en && (cnt_q[rd_a] != '0)) hazard_c = 1'b1;
        if (rd_b_en && (cnt_q[rd_b] != '0)) hazard_c = 1'b1;
        if (wr_en && (cnt_q[wr_addr] == {SB_CNT_W{1'b1}})) hazard_c = 1'b1;
    end

    // Counter and sticky error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/decode_stage.sv
// Registered, flow-controlled decode stage with write scoreboard and RAW stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned NREG     = 8,
    parameter int unsigned SB_CNT_W = 2,
    localparam int unsigned REG_AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output ctrl_t              out_ctrl,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic               flush,
    output logic               sb_err
);

    // Register fields keep only their low REG_AW bits
    localparam logic [FIELD_W-1:0] AW_MASK = FIELD_W'((1 << REG_AW) - 1);

    ctrl_t dec_ctrl_c;
    src_t  src_c;
    dst_t  dst_c;
    ctrl_t ctrl_q;
    ctrl_t ctrl_d;
    logic  out_valid_q;
    logic  out_valid_d;
    logic  hazard_c;
    logic  ready_c;
    logic  issue_c;
    logic  undo_c;

    // Decode the presented instruction
    always_comb begin
        src_c              = src_regs(in_instr);
        dst_c              = dst_reg(in_instr);
        dec_ctrl_c         = decode(in_instr);
        dec_ctrl_c.wr_addr = dst_c.addr & AW_MASK;
    end

    // Handshake: accept when output slot frees up, no hazard and no flush
    always_comb begin
        ready_c  = rst_n & (!out_valid_q | out_ready) & !hazard_c & !flush;
        issue_c  = in_valid & ready_c;
        undo_c   = flush & out_valid_q & ctrl_q.wr;
        in_ready = ready_c;
    end

    // Output register next-state; bundle holds while stalled downstream
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue_c) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output bundle register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
        end
    end

    decode_scoreboard #(
        .NREG     (NREG),
        .SB_CNT_W (SB_CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en    (issue_c & dst_c.en),
        .inc_addr  (REG_AW'(dst_c.addr)),
        .dec_en    (wb_valid),
        .dec_addr  (wb_addr),
        .undo_en   (undo_c),
        .undo_addr (REG_AW'(ctrl_q.wr_addr)),
        .rd_a_en   (src_c.a_en),
        .rd_a      (REG_AW'(src_c.a)),
        .rd_b_en   (src_c.b_en),
        .rd_b      (REG_AW'(src_c.b)),
        .wr_en     (dst_c.en),
        .wr_addr   (REG_AW'(dst_c.addr)),
        .hazard_c  (hazard_c),
        .sb_err    (sb_err)
    );

    assign out_valid = out_valid_q;
    assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, decode fields, scoreboard stalls, flush, sb_err.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    ctrl_t       out_ctrl;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic        flush;
    logic        sb_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decode_stage #(.NREG(8), .SB_CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .flush     (flush),
        .sb_err    (sb_err)
    );

    function automatic logic [15:0] i_alu(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rd);
        return {2'b11, rs, rd, op, 4'h0};
    endfunction
    function automatic logic [15:0] i_load(input logic [2:0] dst, input logic [2:0] base, input logic [7:0] imm);
        return {2'b00, dst, base, imm};
    endfunction
    function automatic logic [15:0] i_store(input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm);
        return {2'b01, a, b, imm};
    endfunction
    function automatic logic [15:0] i_li(input logic [2:0] rd, input logic [7:0] imm);
        return {2'b10, 3'b000, rd, imm};
    endfunction
    function automatic logic [15:0] i_br(input logic [2:0] sub, input logic [2:0] cond, input logic [7:0] imm);
        return {2'b10, sub, cond, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = 3'd0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int nz;
        idle_inputs();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_instr = i_alu(4'b0000, 3'd1, 3'd2);
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL rst_sb_err: got %b want 0", sb_err); end
        tests_run++; if (out_ctrl !== ctrl_t'(0)) begin tests_failed++; $display("FAIL rst_out_ctrl: got %h want 0", out_ctrl); end
        nz = 0;
        for (int i = 0; i < 8; i++) if (dut.u_sb.cnt_q[i] !== 2'd0) nz++;
        tests_run++; if (nz !== 0) begin tests_failed++; $display("FAIL rst_counters: %0d nonzero want 0", nz); end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1;
        in_instr = i_alu(4'b0000, 3'd2, 3'd1);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid0: got %b want 1", out_valid); end
        tests_run++; if (out_ctrl.s_alu !== IADD) begin tests_failed++; $display("FAIL b2b_add_alu: got %h want %h", out_ctrl.s_alu, IADD); end
        tests_run++; if ({out_ctrl.wr, out_ctrl.wr_addr} !== 4'b1_001) begin tests_failed++; $display("FAIL b2b_add_wr: got %b want 1001", {out_ctrl.wr, out_ctrl.wr_addr}); end
        in_instr = i_alu(4'b0101, 3'd4, 3'd5);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
        tests_run++; if (out_ctrl.s_alu !== ISUB) begin tests_failed++; $display("FAIL b2b_cmp_alu: got %h want %h", out_ctrl.s_alu, ISUB); end
        tests_run++; if ({out_ctrl.wr, out_ctrl.flag_write} !== 2'b01) begin tests_failed++; $display("FAIL b2b_cmp_wr_fw: got %b want 01", {out_ctrl.wr, out_ctrl.flag_write}); end
        in_instr = i_alu(4'b0001, 3'd6, 3'd7);
        tick();
        tests_run++; if ({out_ctrl.s_alu, out_ctrl.wr, out_ctrl.wr_addr} !== {ISUB, 1'b1, 3'd7}) begin tests_failed++; $display("FAIL b2b_sub: got %h/%b/%0d want %h/1/7", out_ctrl.s_alu, out_ctrl.wr, out_ctrl.wr_addr, ISUB); end
        in_valid = 1'b0;
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        tests_run++; if ({dut.u_sb.cnt_q[1], dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[7]} !== 6'b01_00_01) begin tests_failed++; $display("FAIL b2b_counters: got %b want 010001", {dut.u_sb.cnt_q[1], dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[7]}); end
    endtask

    task automatic test_raw();
        do_reset();
        in_valid = 1'b1;
        in_instr = i_alu(4'b0000, 3'd1, 3'd3);
        tick();
        in_instr = i_store(3'd3, 3'd0, 8'h10);
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall0: got %b want 0", in_ready); end
        tick();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall1: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b1;
        wb_addr  = 3'd3;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_no_bypass: got %b want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        tests_run++; if ({in_ready, out_valid} !== 2'b10) begin tests_failed++; $display("FAIL raw_release: got ready/valid %b want 10", {in_ready, out_valid}); end
        tick();
        tests_run++; if ({out_valid, out_ctrl.mem_we, out_ctrl.wr} !== 3'b110) begin tests_failed++; $display("FAIL raw_store_issue: got %b want 110", {out_valid, out_ctrl.mem_we, out_ctrl.wr}); end
        tests_run++; if (out_ctrl.imm !== 8'h10) begin tests_failed++; $display("FAIL raw_store_imm: got %h want 10", out_ctrl.imm); end
        in_valid = 1'b0;
        tick();
        tests_run++; if (dut.u_sb.cnt_q[3] !== 2'd0) begin tests_failed++; $display("FAIL raw_cnt3: got %0d want 0", dut.u_sb.cnt_q[3]); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = i_li(3'd1, 8'(k + 1));
            tick();
        end
        in_instr = i_li(3'd1, 8'h44);
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL sat_stall: got %b want 0", in_ready); end
        tests_run++; if ({out_ctrl.s_alu, out_ctrl.wr_addr, out_ctrl.imm} !== {IIDT, 3'd1, 8'h03}) begin tests_failed++; $display("FAIL sat_li3: got %h/%0d/%h want %h/1/03", out_ctrl.s_alu, out_ctrl.wr_addr, out_ctrl.imm, IIDT); end
        tick();
        tests_run++; if ({in_ready, dut.u_sb.cnt_q[1]} !== 3'b0_11) begin tests_failed++; $display("FAIL sat_hold: got ready/cnt %b want 011", {in_ready, dut.u_sb.cnt_q[1]}); end
        wb_valid = 1'b1;
        wb_addr  = 3'd1;
        tick();
        wb_valid = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL sat_release: got %b want 1", in_ready); end
        tick();
        tests_run++; if ({out_valid, out_ctrl.imm} !== {1'b1, 8'h44}) begin tests_failed++; $display("FAIL sat_issue4: got %b/%h want 1/44", out_valid, out_ctrl.imm); end
        in_valid = 1'b0;
        tick();
        tests_run++; if (dut.u_sb.cnt_q[1] !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt1: got %0d want 3", dut.u_sb.cnt_q[1]); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = i_li(3'd2, 8'h5A);
        tick();
        in_instr = i_store(3'd2, 3'd0, 8'h21);
        #1;
        tests_run++; if ({in_ready, out_valid, dut.u_sb.cnt_q[2]} !== 4'b0_1_01) begin tests_failed++; $display("FAIL flush_pre: got ready/valid/cnt %b want 0101", {in_ready, out_valid, dut.u_sb.cnt_q[2]}); end
        tick();
        tests_run++; if ({out_valid, out_ctrl.wr_addr, out_ctrl.imm} !== {1'b1, 3'd2, 8'h5A}) begin tests_failed++; $display("FAIL flush_hold: got %b/%0d/%h want 1/2/5a", out_valid, out_ctrl.wr_addr, out_ctrl.imm); end
        flush = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        tests_run++; if ({out_valid, dut.u_sb.cnt_q[2], in_ready} !== 4'b0_00_1) begin tests_failed++; $display("FAIL flush_after: got valid/cnt/ready %b want 0001", {out_valid, dut.u_sb.cnt_q[2], in_ready}); end
        tick();
        tests_run++; if ({out_valid, out_ctrl.mem_we, out_ctrl.imm} !== {2'b11, 8'h21}) begin tests_failed++; $display("FAIL flush_reader: got %b/%b/%h want 1/1/21", out_valid, out_ctrl.mem_we, out_ctrl.imm); end
        in_valid = 1'b0;
    endtask

    task automatic test_sb_err();
        do_reset();
        wb_valid = 1'b1;
        wb_addr  = 3'd5;
        tick();
        wb_valid = 1'b0;
        tests_run++; if ({sb_err, dut.u_sb.cnt_q[5]} !== 3'b1_00) begin tests_failed++; $display("FAIL sberr_set: got err/cnt %b want 100", {sb_err, dut.u_sb.cnt_q[5]}); end
        repeat (3) tick();
        tests_run++; if ({sb_err, in_ready} !== 2'b11) begin tests_failed++; $display("FAIL sberr_sticky: got err/ready %b want 11", {sb_err, in_ready}); end
    endtask

    task automatic test_flush_wb();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = i_li(3'd2, 8'h01);
        tick();
        in_valid = 1'b0;
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL fwb_pre_err: got %b want 0", sb_err); end
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 3'd2;
        tick();
        flush    = 1'b0;
        wb_valid = 1'b0;
        tests_run++; if ({out_valid, dut.u_sb.cnt_q[2], sb_err} !== 4'b0_00_1) begin tests_failed++; $display("FAIL fwb_floor: got valid/cnt/err %b want 0001", {out_valid, dut.u_sb.cnt_q[2], sb_err}); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        in_valid = 1'b1;
        in_instr = i_li(3'd6, 8'h01);
        tick();
        in_instr = i_li(3'd6, 8'h02);
        wb_valid = 1'b1;
        wb_addr  = 3'd6;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL same_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b0;
        tests_run++; if ({dut.u_sb.cnt_q[6], sb_err, out_ctrl.imm} !== {2'd1, 1'b0, 8'h02}) begin tests_failed++; $display("FAIL same_net: got cnt/err/imm %0d/%b/%h want 1/0/02", dut.u_sb.cnt_q[6], sb_err, out_ctrl.imm); end
    endtask

    task automatic test_decode();
        do_reset();
        in_valid = 1'b1;
        in_instr = i_load(3'd4, 3'd6, 8'h85);
        tick();
        tests_run++; if ({out_ctrl.wr, out_ctrl.wr_addr, out_ctrl.in_mux, out_ctrl.sign_ex, out_ctrl.s_alu} !== {1'b1, 3'd4, 2'b11, IADD}) begin tests_failed++; $display("FAIL dec_load: got %h want load r4", out_ctrl); end
        tests_run++; if (out_ctrl.imm !== 8'h85) begin tests_failed++; $display("FAIL dec_load_imm: got %h want 85", out_ctrl.imm); end
        in_instr = i_br(3'b011, 3'd5, 8'hF0);
        tick();
        tests_run++; if ({out_ctrl.pc_load, out_ctrl.cond, out_ctrl.wr, out_ctrl.imm} !== {1'b1, 3'd5, 1'b0, 8'hF0}) begin tests_failed++; $display("FAIL dec_branch: got %h want branch cond 5", out_ctrl); end
        in_instr = i_alu(4'b1101, 3'd1, 3'd2);
        tick();
        tests_run++; if ({out_valid, out_ctrl.out_en, out_ctrl.wr} !== 3'b110) begin tests_failed++; $display("FAIL dec_out: got %b want 110", {out_valid, out_ctrl.out_en, out_ctrl.wr}); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_raw();
        test_saturation();
        test_flush();
        test_sb_err();
        test_flush_wb();
        test_same_cycle();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
